// File: rtl/param_rom_fsm.sv
// Table-driven Mealy FSM. The next-state/output table is a writable array that clears itself
// after reset or cfg_clr; the host then loads it through the config port.
module param_rom_fsm #(
  parameter int unsigned STATE_W     = 2,
  parameter int unsigned IN_W        = 1,
  parameter int unsigned OUT_W       = 1,
  parameter int unsigned RESET_STATE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [IN_W-1:0]            x_in,
  output logic [OUT_W-1:0]           z_out,
  output logic [STATE_W-1:0]         state_out,
  input  logic                       cfg_we,
  input  logic [STATE_W+IN_W-1:0]    cfg_addr,
  input  logic [STATE_W+OUT_W-1:0]   cfg_data,
  input  logic                       cfg_clr,
  output logic                       cfg_ready
);

  localparam int unsigned ADDR_W  = STATE_W + IN_W;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned ENTRY_W = STATE_W + OUT_W;

  localparam logic [STATE_W-1:0] ResetState = STATE_W'(RESET_STATE);
  localparam logic [ADDR_W-1:0]  LastAddr   = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StRun} ctrl_e;

  ctrl_e               ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [OUT_W-1:0]    z_q, z_d;

  logic [ENTRY_W-1:0]  tbl_q [DEPTH];
  logic                tbl_we;
  logic [ADDR_W-1:0]   tbl_waddr;
  logic [ENTRY_W-1:0]  tbl_wdata;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ENTRY_W-1:0]  rd_entry;

  assign rd_addr  = {state_q, x_in};
  assign rd_entry = tbl_q[rd_addr];

  always_comb begin
    ctrl_d    = ctrl_q;
    clr_ptr_d = clr_ptr_q;
    state_d   = state_q;
    z_d       = z_q;
    tbl_we    = 1'b0;
    tbl_waddr = clr_ptr_q;
    tbl_wdata = '0;
    case (ctrl_q)
      StClear: begin
        // Host inputs are ignored until every entry holds a defined value.
        tbl_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LastAddr) begin
          ctrl_d = StRun;
        end
      end
      StRun: begin
        if (cfg_clr) begin
          ctrl_d    = StClear;
          clr_ptr_d = '0;
          state_d   = ResetState;
          z_d       = '0;
        end else if (cfg_we) begin
          // Writes stall the FSM so a lookup never races the entry being changed.
          tbl_we    = 1'b1;
          tbl_waddr = cfg_addr;
          tbl_wdata = cfg_data;
        end else if (en) begin
          state_d = rd_entry[ENTRY_W-1:OUT_W];
          z_d     = rd_entry[OUT_W-1:0];
        end
      end
      default: ctrl_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= StClear;
      clr_ptr_q <= '0;
      state_q   <= ResetState;
      z_q       <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      clr_ptr_q <= clr_ptr_d;
      state_q   <= state_d;
      z_q       <= z_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[tbl_waddr] <= tbl_wdata;
    end
  end

  assign state_out = state_q;
  assign z_out     = z_q;
  assign cfg_ready = (ctrl_q == StRun);

endmodule

// File: tb/tb_param_rom_fsm.sv
// Directed bench for param_rom_fsm: expected {ready, state, z} are queued as each step is driven
// and popped for comparison once the DUT has responded.
module tb_param_rom_fsm;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned IN_W    = 1;
  localparam int unsigned OUT_W   = 1;
  localparam int unsigned ADDR_W  = STATE_W + IN_W;
  localparam int unsigned ENTRY_W = STATE_W + OUT_W;
  localparam int unsigned OBS_W   = 1 + STATE_W + OUT_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                en;
  logic [IN_W-1:0]     x_in;
  logic [OUT_W-1:0]    z_out;
  logic [STATE_W-1:0]  state_out;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [ENTRY_W-1:0]  cfg_data;
  logic                cfg_clr;
  logic                cfg_ready;

  int checks = 0;
  int errors = 0;
  logic [OBS_W-1:0] exp_q[$];

  param_rom_fsm #(
    .STATE_W    (STATE_W),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .RESET_STATE(0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .x_in     (x_in),
    .z_out    (z_out),
    .state_out(state_out),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_clr  (cfg_clr),
    .cfg_ready(cfg_ready)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag);
    logic [OBS_W-1:0] exp;
    logic [OBS_W-1:0] obs;
    exp = exp_q.pop_front();
    obs = {cfg_ready, state_out, z_out};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed {rdy,st,z}=%b required=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic step(input string tag, input logic e, input logic [IN_W-1:0] x,
                      input logic we, input logic [ADDR_W-1:0] a, input logic [ENTRY_W-1:0] d,
                      input logic c, input logic rdy, input logic [STATE_W-1:0] s,
                      input logic [OUT_W-1:0] z);
    en       = e;
    x_in     = x;
    cfg_we   = we;
    cfg_addr = a;
    cfg_data = d;
    cfg_clr  = c;
    exp_q.push_back({rdy, s, z});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic idle_step(input string tag, input logic e, input logic [IN_W-1:0] x,
                           input logic rdy, input logic [STATE_W-1:0] s,
                           input logic [OUT_W-1:0] z);
    step(tag, e, x, 1'b0, '0, '0, 1'b0, rdy, s, z);
  endtask

  task automatic write(input string tag, input logic [ADDR_W-1:0] a,
                       input logic [ENTRY_W-1:0] d, input logic [STATE_W-1:0] s,
                       input logic [OUT_W-1:0] z);
    step(tag, 1'b1, '0, 1'b1, a, d, 1'b0, 1'b1, s, z);
  endtask

  // Full clear: ready must stay low for 7 edges and rise on the 8th; host inputs ignored.
  task automatic clear_wait(input string tag);
    for (int i = 0; i < 8; i++) begin
      step(tag, 1'b1, IN_W'(i), 1'b1, ADDR_W'(i), '1, 1'b0, (i == 7), '0, '0);
    end
  endtask

  initial begin
    logic [ENTRY_W-1:0] prog [8];
    prog[0] = 3'b000; prog[1] = 3'b010; prog[2] = 3'b100; prog[3] = 3'b010;
    prog[4] = 3'b110; prog[5] = 3'b010; prog[6] = 3'b001; prog[7] = 3'b010;

    reset = 1'b0; en = 1'b0; x_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back('0);
    compare("reset_state");
    reset = 1'b1;
    clear_wait("init_clear");

    for (int i = 0; i < 4; i++) idle_step("cleared_table", 1'b1, IN_W'(i), 1'b1, 2'd0, 1'b0);

    for (int i = 0; i < 8; i++) write("program", ADDR_W'(i), prog[i], 2'd0, 1'b0);

    idle_step("det_x1", 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
    idle_step("det_x0a", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) idle_step("stall_en0", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    write("stall_we", 3'd7, 3'b010, 2'd2, 1'b0);
    idle_step("det_x0b", 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    idle_step("det_x0c", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
    idle_step("hold_z1", 1'b0, 1'b1, 1'b1, 2'd0, 1'b1);

    write("wr_addr0", 3'd0, 3'b011, 2'd0, 1'b1);
    idle_step("use_addr0", 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);

    step("clr_with_we", 1'b1, 1'b0, 1'b1, 3'd2, 3'b111, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step("clr_wait", 1'b1, IN_W'(i), 1'b1, 3'd0, 3'b111, 1'b0, (i == 7), 2'd0, 1'b0);
    end
    idle_step("post_clr_x0", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    idle_step("post_clr_x1", 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    write("wr_addr1", 3'd1, 3'b010, 2'd0, 1'b0);
    idle_step("to_s1", 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
    idle_step("addr2_zero", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);

    write("wr_addr1b", 3'd1, 3'b011, 2'd0, 1'b0);
    idle_step("pre_rst_run", 1'b1, 1'b1, 1'b1, 2'd1, 1'b1);
    #3 reset = 1'b0;
    #1;
    exp_q.push_back('0);
    compare("async_rst_run");
    @(posedge clk);
    #1 reset = 1'b1;
    clear_wait("run_rst_clear");

    idle_step("mid_clr_setup", 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    step("mid_clr_req", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) idle_step("mid_clr_pre", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    #3 reset = 1'b0;
    #1;
    exp_q.push_back('0);
    compare("async_rst_clear");
    @(posedge clk);
    #1 reset = 1'b1;
    clear_wait("clr_rst_clear");
    idle_step("final_step", 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);

    checks++;
    assert (exp_q.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
